// File: rtl/i2c_target_responder.sv
// I2C target responder: oversampled SCL/SDA, address match,
// RX/TX byte FIFOs with backpressure NACK and underrun fill.
module i2c_target_responder #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h22,
  parameter int FIFO_DEPTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_oe_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  busy_o,
  output logic                  op_o,
  output logic                  start_o,
  output logic                  stop_o,
  output logic                  rx_overflow_o,
  output logic                  tx_underrun_o
);

  localparam int SW = (ADDR_WIDTH + 1 > DATA_WIDTH)
                    ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int CW = $clog2(SW + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] ADDR_BITS = CW'(ADDR_WIDTH + 1);
  localparam logic [CW-1:0] DATA_BITS = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA,
    S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_det, stop_det;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign sda_rise  = sda_s & ~sda_d;
  assign sda_fall  = ~sda_s & sda_d;
  assign start_det = sda_fall & scl_s;
  assign stop_det  = sda_rise & scl_s;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [SW-1:0] shift, shift_n;
  logic [DATA_WIDTH-1:0] tx_sh, tx_sh_n;
  logic ack, ack_n;
  logic oe_n, op_n, busy_n;
  logic start_n, stop_n, ovf_n, unr_n;
  logic rx_push, tx_pop, load_rd;

  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_rd, rx_wr, tx_rd, tx_wr;
  logic [AW:0]   rx_cnt, tx_cnt;
  logic rx_full, tx_empty, rx_pop, tx_push;
  logic [DATA_WIDTH-1:0] tx_head;

  assign rx_full    = (rx_cnt == FULL_CNT);
  assign tx_empty   = (tx_cnt == '0);
  assign rx_valid_o = (rx_cnt != '0);
  assign tx_ready_o = (tx_cnt != FULL_CNT);
  assign rx_data_o  = rx_mem[rx_rd];
  assign tx_head    = tx_mem[tx_rd];
  assign rx_pop     = rx_valid_o & rx_ready_i;
  assign tx_push    = tx_valid_i & tx_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      cnt           <= '0;
      shift         <= '0;
      tx_sh         <= '1;
      ack           <= 1'b1;
      sda_oe_o      <= 1'b0;
      op_o          <= 1'b0;
      busy_o        <= 1'b0;
      start_o       <= 1'b0;
      stop_o        <= 1'b0;
      rx_overflow_o <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      shift         <= shift_n;
      tx_sh         <= tx_sh_n;
      ack           <= ack_n;
      sda_oe_o      <= oe_n;
      op_o          <= op_n;
      busy_o        <= busy_n;
      start_o       <= start_n;
      stop_o        <= stop_n;
      rx_overflow_o <= ovf_n;
      tx_underrun_o <= unr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    tx_sh_n = tx_sh;
    ack_n   = ack;
    oe_n    = sda_oe_o;
    op_n    = op_o;
    busy_n  = busy_o;
    start_n = 1'b0;
    stop_n  = 1'b0;
    ovf_n   = 1'b0;
    unr_n   = 1'b0;
    rx_push = 1'b0;
    tx_pop  = 1'b0;
    load_rd = 1'b0;
    if (start_det) begin
      state_n = S_ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      start_n = 1'b1;
    end else if (stop_det) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      stop_n  = 1'b1;
    end else begin
      unique case (state)
        S_ADDR, S_WR_DATA: begin
          if (scl_rise) begin
            shift_n = {shift[SW-2:0], sda_s};
            cnt_n   = cnt + CW'(1);
          end else if (scl_fall && state == S_ADDR
                       && cnt == ADDR_BITS) begin
            if (shift[ADDR_WIDTH:1] == TARGET_ADDR) begin
              state_n = S_ADDR_ACK;
              oe_n    = 1'b1;
              op_n    = shift[0];
              busy_n  = 1'b1;
            end else begin
              state_n = S_IGNORE;
              oe_n    = 1'b0;
            end
          end else if (scl_fall && state == S_WR_DATA
                       && cnt == DATA_BITS) begin
            state_n = S_WR_ACK;
            // A full RX FIFO is signalled to the controller as NACK
            if (rx_full) begin
              ovf_n = 1'b1;
            end else begin
              rx_push = 1'b1;
              oe_n    = 1'b1;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (op_o) begin
              load_rd = 1'b1;
            end else begin
              state_n = S_WR_DATA;
              cnt_n   = '0;
              oe_n    = 1'b0;
            end
          end
        end
        S_WR_ACK: begin
          if (scl_fall) begin
            state_n = S_WR_DATA;
            cnt_n   = '0;
            oe_n    = 1'b0;
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            if (cnt == LAST_BIT) begin
              state_n = S_RD_ACK;
              oe_n    = 1'b0;
            end else begin
              tx_sh_n = {tx_sh[DATA_WIDTH-2:0], 1'b1};
              oe_n    = ~tx_sh[DATA_WIDTH-2];
              cnt_n   = cnt + CW'(1);
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            ack_n = sda_s;
          end else if (scl_fall) begin
            if (!ack) begin
              load_rd = 1'b1;
            end else begin
              state_n = S_IGNORE;
              oe_n    = 1'b0;
            end
          end
        end
        default: ;
      endcase
      if (load_rd) begin
        state_n = S_RD_DATA;
        cnt_n   = '0;
        // Underrun sends all-ones, i.e. SDA stays released
        if (tx_empty) begin
          tx_sh_n = '1;
          unr_n   = 1'b1;
        end else begin
          tx_sh_n = tx_head;
          tx_pop  = 1'b1;
        end
        oe_n = ~tx_sh_n[DATA_WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wr] <= shift[DATA_WIDTH-1:0];
    if (tx_push) tx_mem[tx_wr] <= tx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_rd  <= '0;
      rx_wr  <= '0;
      rx_cnt <= '0;
      tx_rd  <= '0;
      tx_wr  <= '0;
      tx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + AW'(1);
      unique case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + (AW+1)'(1);
        2'b01:   rx_cnt <= rx_cnt - (AW+1)'(1);
        default: ;
      endcase
      if (tx_push) tx_wr <= tx_wr + AW'(1);
      if (tx_pop)  tx_rd <= tx_rd + AW'(1);
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + (AW+1)'(1);
        2'b01:   tx_cnt <= tx_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: bit-banged I2C controller,
// RX scoreboard monitor and pulse counters.
module tb_i2c_target_responder;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       rx_ready = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sda_oe, rx_valid, tx_ready, busy, op;
  logic       start_p, stop_p, ovf_p, unr_p;
  logic [7:0] rx_data;
  logic       sda_bus;

  assign sda_bus = sda_drv & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_responder dut (
    .clk_i(clk), .rst_i(rst),
    .scl_i(scl_drv), .sda_i(sda_bus),
    .sda_oe_o(sda_oe),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .rx_ready_i(rx_ready),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .busy_o(busy), .op_o(op),
    .start_o(start_p), .stop_o(stop_p),
    .rx_overflow_o(ovf_p), .tx_underrun_o(unr_p)
  );

  int errors = 0;
  int checks = 0;
  int n_start = 0, n_stop = 0, n_ovf = 0, n_unr = 0;
  logic oe_seen = 1'b0;
  logic busy_seen = 1'b0;
  logic [7:0] exp_rx[$];

  function automatic void check(string name,
                                logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (start_p) n_start++;
      if (stop_p)  n_stop++;
      if (ovf_p)   n_ovf++;
      if (unr_p)   n_unr++;
      if (sda_oe)  oe_seen = 1'b1;
      if (busy)    busy_seen = 1'b1;
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0)
          check("rx_unexpected_pop", {24'h0, rx_data}, 32'hx);
        else
          check("rx_data", {24'h0, rx_data},
                {24'h0, exp_rx.pop_front()});
      end
    end
  end

  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_drv = 1'b1; wq();
    scl_drv = 1'b1; wq();
    sda_drv = 1'b0; wq();
    scl_drv = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wq();
    scl_drv = 1'b1; wq();
    sda_drv = 1'b1; wq();
  endtask

  task automatic bit_x(input logic b, output logic r);
    sda_drv = b;    wq();
    scl_drv = 1'b1; wq();
    r = sda_bus;    wq();
    scl_drv = 1'b0; wq();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], r);
    bit_x(1'b1, ack);
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
    bit_x(ack, r);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rx_ready = 1'b1;
    while (exp_rx.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    rx_ready = 1'b0;
    check("drain_left", exp_rx.size(), 0);
    check("rx_empty_after_drain", {31'h0, rx_valid}, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    logic [7:0] d;
    int s0, p0, u0, v0;

    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_sda_oe", {31'h0, sda_oe}, 0);
    check("rst_rx_valid", {31'h0, rx_valid}, 0);
    check("rst_tx_ready", {31'h0, tx_ready}, 1);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_op", {31'h0, op}, 0);

    // write A5, 3C to 0x22
    s0 = n_start; p0 = n_stop;
    i2c_start();
    wr_byte(8'h44, a);
    check("t1_addr_ack", {31'h0, a}, 0);
    check("t1_busy", {31'h0, busy}, 1);
    check("t1_op", {31'h0, op}, 0);
    wr_byte(8'hA5, a);
    check("t1_b0_ack", {31'h0, a}, 0);
    wr_byte(8'h3C, a);
    check("t1_b1_ack", {31'h0, a}, 0);
    i2c_stop();
    check("t1_busy_after_stop", {31'h0, busy}, 0);
    check("t1_starts", n_start - s0, 1);
    check("t1_stops", n_stop - p0, 1);
    exp_rx.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    drain();

    // foreign address 0x23
    oe_seen = 1'b0;
    busy_seen = 1'b0;
    i2c_start();
    wr_byte(8'h46, a);
    check("t2_addr_nack", {31'h0, a}, 1);
    wr_byte(8'h99, a);
    i2c_stop();
    check("t2_oe_seen", {31'h0, oe_seen}, 0);
    check("t2_busy_seen", {31'h0, busy_seen}, 0);
    check("t2_rx_valid", {31'h0, rx_valid}, 0);

    // read 81, 7E
    u0 = n_unr;
    push_tx(8'h81);
    push_tx(8'h7E);
    i2c_start();
    wr_byte(8'h45, a);
    check("t3_addr_ack", {31'h0, a}, 0);
    check("t3_op", {31'h0, op}, 1);
    rd_byte(d, 1'b0);
    check("t3_byte0", {24'h0, d}, 32'h81);
    rd_byte(d, 1'b1);
    check("t3_byte1", {24'h0, d}, 32'h7E);
    check("t3_busy_ignore", {31'h0, busy}, 1);
    check("t3_oe_ignore", {31'h0, sda_oe}, 0);
    i2c_stop();
    check("t3_busy_idle", {31'h0, busy}, 0);
    check("t3_underrun", n_unr - u0, 0);

    // underrun: TX holds only 55
    u0 = n_unr;
    push_tx(8'h55);
    i2c_start();
    wr_byte(8'h45, a);
    check("t4_addr_ack", {31'h0, a}, 0);
    rd_byte(d, 1'b0);
    check("t4_byte0", {24'h0, d}, 32'h55);
    rd_byte(d, 1'b1);
    check("t4_byte1", {24'h0, d}, 32'hFF);
    i2c_stop();
    check("t4_underrun", n_unr - u0, 1);

    // overflow: 9 bytes into 8-deep FIFO
    v0 = n_ovf;
    i2c_start();
    wr_byte(8'h44, a);
    check("t5_addr_ack", {31'h0, a}, 0);
    for (int i = 0; i < 9; i++) begin
      wr_byte(8'(i), a);
      check($sformatf("t5_ack%0d", i), {31'h0, a},
            (i == 8) ? 32'd1 : 32'd0);
    end
    i2c_stop();
    check("t5_overflow", n_ovf - v0, 1);
    check("t5_tx_ready", {31'h0, tx_ready}, 1);
    for (int i = 0; i < 8; i++) exp_rx.push_back(8'(i));
    drain();

    // write 11, repeated START, read C3
    s0 = n_start; p0 = n_stop;
    push_tx(8'hC3);
    i2c_start();
    wr_byte(8'h44, a);
    check("t6_w_ack", {31'h0, a}, 0);
    check("t6_op_w", {31'h0, op}, 0);
    wr_byte(8'h11, a);
    check("t6_b_ack", {31'h0, a}, 0);
    i2c_start();
    wr_byte(8'h45, a);
    check("t6_r_ack", {31'h0, a}, 0);
    check("t6_op_r", {31'h0, op}, 1);
    rd_byte(d, 1'b1);
    check("t6_rbyte", {24'h0, d}, 32'hC3);
    i2c_stop();
    check("t6_starts", n_start - s0, 2);
    check("t6_stops", n_stop - p0, 1);
    exp_rx.push_back(8'h11);
    drain();

    // reset in the middle of a read
    i2c_start();
    wr_byte(8'h44, a);
    wr_byte(8'h99, a);
    i2c_stop();
    check("t7_rx_loaded", {31'h0, rx_valid}, 1);
    push_tx(8'h3C);
    push_tx(8'h5A);
    i2c_start();
    wr_byte(8'h45, a);
    check("t7_addr_ack", {31'h0, a}, 0);
    check("t7_oe_driving", {31'h0, sda_oe}, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t7_oe_released", {31'h0, sda_oe}, 0);
    check("t7_rx_empty", {31'h0, rx_valid}, 0);
    check("t7_busy", {31'h0, busy}, 0);
    check("t7_tx_ready", {31'h0, tx_ready}, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    i2c_stop();
    u0 = n_unr;
    i2c_start();
    wr_byte(8'h45, a);
    check("t7_re_ack", {31'h0, a}, 0);
    rd_byte(d, 1'b1);
    check("t7_tx_flushed", {24'h0, d}, 32'hFF);
    i2c_stop();
    check("t7_underrun", n_unr - u0, 1);

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- Synthesizable, clocked successor to the I2C slave BFM: oversamples SCL/SDA on the system clock, detects START/repeated START/STOP, decodes address and R/W, and ACKs only its own address.
- Write bytes go into an RX FIFO; read bytes come from a TX FIFO.
- Sits beside the I2CMB DUT on the shared open-drain bus as an on-chip target and self-checking responder, with FIFO-backpressure NACK and underrun/overflow reporting.

Parameters:
ADDR_WIDTH, 7, target address width
DATA_WIDTH, 8, data byte width
TARGET_ADDR, 7'h22, address this block responds to
FIFO_DEPTH, 8, entries per RX and TX FIFO (power of two, >=2)
SYNC_STAGES, 2, synchronizer flops on scl_i/sda_i (>=2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
scl_i  in  1  bus SCL (async)
sda_i  in  1  bus SDA (async)
sda_oe_o  out  1  1 = pull SDA low; 0 = release
rx_data_o  out  DATA_WIDTH  head of RX FIFO
rx_valid_o  out  1  RX FIFO not empty
rx_ready_i  in  1  pop RX head when rx_valid_o & rx_ready_i
tx_data_i  in  DATA_WIDTH  read byte to enqueue
tx_valid_i  in  1  push when tx_valid_i & tx_ready_o
tx_ready_o  out  1  TX FIFO not full
busy_o  out  1  addressed transfer in progress (ADDR_ACK through its terminating START/STOP)
op_o  out  1  R/W bit of last matched address (1 = read)
start_o  out  1  1-cycle pulse on START or repeated START
stop_o  out  1  1-cycle pulse on STOP
rx_overflow_o  out  1  1-cycle pulse: write byte NACKed, FIFO full
tx_underrun_o  out  1  1-cycle pulse: read byte needed, TX FIFO empty

Behaviour:
- Reset: sda_oe_o=0, rx_valid_o=0, tx_ready_o=1, busy_o=0, op_o=0, all pulses 0. Both FIFOs emptied, FSM=IDLE, synchronizers preset to 1. Reset mid-transfer releases SDA on the first clock after rst_i is sampled.
- Input path: SYNC_STAGES flops, then one delay register. scl_rise/scl_fall/sda_rise/sda_fall are one-cycle strobes. Bus-to-strobe latency is SYNC_STAGES+1 clocks.
- START = sda_fall with scl high; STOP = sda_rise with scl high. Both override every state.
  - START -> ADDR, bit counter cleared, start_o pulsed.
  - STOP -> IDLE, sda_oe_o=0, stop_o pulsed.
- Sampling and driving:
  - SDA is sampled only on scl_rise. A data bit counter wraps 0..DATA_WIDTH-1 (7..0, MSB first).
  - sda_oe_o changes only on scl_fall, except STOP, START and reset, which release it immediately.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift ADDR_WIDTH address bits, then the R/W bit. On the following scl_fall:
    - match TARGET_ADDR -> ADDR_ACK, sda_oe_o=1, op_o latched, busy_o=1;
    - mismatch -> IGNORE, SDA released.
  - ADDR_ACK: on next scl_fall:
    - write -> release SDA, go WR_DATA;
    - read -> go RD_DATA and drive bit MSB of the TX byte.
  - WR_DATA: shift DATA_WIDTH bits. On the scl_fall after the last bit -> WR_ACK:
    - RX not full: push byte, sda_oe_o=1;
    - RX full: discard byte, keep SDA released (NACK), pulse rx_overflow_o.
  - WR_ACK: on next scl_fall release SDA -> WR_DATA.
  - RD_DATA: load TX byte on entry:
    - TX non-empty: pop FIFO;
    - TX empty: byte = all-ones (SDA released), pulse tx_underrun_o.
    - sda_oe_o = ~bit, updated each scl_fall.
    - After the last bit's scl_fall, release SDA -> RD_ACK.
  - RD_ACK: sample controller ACK on scl_rise. On scl_fall:
    - ACK (0) -> RD_DATA with next byte;
    - NACK (1) -> IGNORE.
  - IGNORE: SDA released; wait for START/STOP. busy_o=0 once START/STOP is seen.
- FIFOs:
  - Simultaneous push and pop in the same clock both take effect; count is unchanged.
  - Push when full and pop when empty are ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_data_o is valid combinationally from the head entry.
- A START in the middle of any byte abandons the partial byte; it is not pushed.

Test Plan:
- Reset then write to addr 0x22 with bytes 0xA5, 0x3C and STOP -> ACK on address and both bytes; RX pops 0xA5 then 0x3C; start_o and stop_o each pulse once; busy_o falls after STOP.
- Write to addr 0x23 -> SDA never pulled low; RX FIFO stays empty; busy_o stays 0.
- Push TX 0x81, 0x7E; read from 0x22, controller ACKs byte 1 and NACKs byte 2 -> bus shows 0x81, 0x7E; FSM ends in IGNORE, then IDLE on STOP; no tx_underrun_o.
- Read 2 bytes with the TX FIFO holding only 0x55 -> bytes 0x55, 0xFF; tx_underrun_o pulses exactly once.
- FIFO_DEPTH=8, write 9 bytes 0x00..0x08 without popping -> first 8 ACKed, 9th NACKed; rx_overflow_o pulses once; the pop order is 0x00..0x07.
- Write 0x11, repeated START, read 1 byte (TX 0xC3), STOP; separately assert rst_i mid-read with sda_oe_o=1 -> start_o pulses twice and op_o goes 0 then 1; on reset, sda_oe_o=0 one clock later and both FIFOs are empty.
